// File: rtl/jts16_bank_sched_if.sv
// Bank-port and SDRAM-command bundle for jts16_bank_sched.
// master: the scheduler side; slave: banks plus SDRAM controller.
interface jts16_bank_sched_if #(
    parameter int unsigned AW = 22
);
    logic          downloading;
    logic [3:0]    ba_rd;
    logic          ba_wr;
    logic [AW-1:0] ba0_addr;
    logic [AW-1:0] ba1_addr;
    logic [AW-1:0] ba2_addr;
    logic [AW-1:0] ba3_addr;
    logic [15:0]   ba0_din;
    logic [1:0]    ba0_din_m;
    logic [3:0]    ba_ack;
    logic [3:0]    ba_dst;
    logic [3:0]    ba_dok;
    logic [3:0]    ba_rdy;
    logic          sch_err;
    logic          cmd_req;
    logic          cmd_wr;
    logic [1:0]    cmd_ba;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_din;
    logic [1:0]    cmd_mask;
    logic [1:0]    cmd_len;
    logic          cmd_ack;
    logic          cmd_dst;
    logic          cmd_dok;
    logic          cmd_rdy;
    logic          rfsh_req;
    logic          rfsh_ack;

    modport master (
        input  downloading, ba_rd, ba_wr, ba0_addr, ba1_addr, ba2_addr, ba3_addr,
        input  ba0_din, ba0_din_m,
        output ba_ack, ba_dst, ba_dok, ba_rdy, sch_err,
        output cmd_req, cmd_wr, cmd_ba, cmd_addr, cmd_din, cmd_mask, cmd_len,
        input  cmd_ack, cmd_dst, cmd_dok, cmd_rdy,
        output rfsh_req,
        input  rfsh_ack
    );

    modport slave (
        output downloading, ba_rd, ba_wr, ba0_addr, ba1_addr, ba2_addr, ba3_addr,
        output ba0_din, ba0_din_m,
        input  ba_ack, ba_dst, ba_dok, ba_rdy, sch_err,
        input  cmd_req, cmd_wr, cmd_ba, cmd_addr, cmd_din, cmd_mask, cmd_len,
        output cmd_ack, cmd_dst, cmd_dok, cmd_rdy,
        input  rfsh_req,
        output rfsh_ack
    );
endinterface

// File: rtl/jts16_bank_sched.sv
// Round-robin scheduler of four S16 bank ports onto one SDRAM command port, with auto-refresh.
// Optional JTS16_BANK_PRIO_EN: bank 0 wins over banks 1-3 (urgent refresh still wins over it).
module jts16_bank_sched #(
    parameter int unsigned AW          = 22,
    parameter int unsigned REFRESH_CYC = 384,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned LEN0        = 1,
    parameter int unsigned LEN1        = 1,
    parameter int unsigned LEN2        = 2,
    parameter int unsigned LEN3        = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jts16_bank_sched_if.master     bus
);
    localparam int unsigned CW = $clog2(3 * REFRESH_CYC + 1);
    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RFSH} state_t;

    typedef struct packed {
        logic          wr;
        logic [1:0]    ba;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [1:0]    mask;
        logic [1:0]    len;
    } cmd_t;

    state_t        r_state, w_state_nx;
    logic [1:0]    r_ptr, w_ptr_nx;
    cmd_t          r_cmd, w_cmd_nx;
    logic [TW-1:0] r_tmo, w_tmo_nx;
    logic [CW-1:0] r_cnt;
    logic          r_cmd_req, r_rfsh_req, r_sch_err, w_err_nx;
    logic [3:0]    r_ba_ack, w_ack_nx;
    logic          w_rfsh_done;
    logic [3:0]    w_elig, w_rr;
    logic          w_found;
    logic [1:0]    w_pick, w_idx;
    logic          w_urgent, w_pending;
    logic [3:0]    w_sel;

    assign w_elig    = bus.downloading ? 4'b0000 : {bus.ba_rd[3:1], bus.ba_rd[0] | bus.ba_wr};
    assign w_urgent  = r_cnt >= CW'(2 * REFRESH_CYC);
    assign w_pending = r_cnt >= CW'(REFRESH_CYC);
    assign w_sel     = 4'b0001 << r_cmd.ba;

    // First eligible bank after ptr; bank 0 may bypass the rotation
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        w_idx   = 2'd0;
`ifdef JTS16_BANK_PRIO_EN
        w_rr = {w_elig[3:1], 1'b0};
`else
        w_rr = w_elig;
`endif
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && w_rr[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
`ifdef JTS16_BANK_PRIO_EN
        if (w_elig[0]) begin
            w_found = 1'b1;
            w_pick  = 2'd0;
        end
`endif
    end

    always_comb begin
        w_state_nx  = r_state;
        w_ptr_nx    = r_ptr;
        w_cmd_nx    = r_cmd;
        w_tmo_nx    = r_tmo;
        w_ack_nx    = 4'b0000;
        w_err_nx    = 1'b0;
        w_rfsh_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_urgent || (w_pending && !w_found)) begin
                    w_state_nx = S_RFSH;
                end else if (w_found) begin
                    w_state_nx    = S_ISSUE;
                    w_cmd_nx.wr   = bus.ba_wr && (w_pick == 2'd0);
                    w_cmd_nx.ba   = w_pick;
                    w_cmd_nx.din  = bus.ba0_din;
                    w_cmd_nx.mask = bus.ba0_din_m;
                    case (w_pick)
                        2'd0: begin w_cmd_nx.addr = bus.ba0_addr; w_cmd_nx.len = 2'(LEN0); end
                        2'd1: begin w_cmd_nx.addr = bus.ba1_addr; w_cmd_nx.len = 2'(LEN1); end
                        2'd2: begin w_cmd_nx.addr = bus.ba2_addr; w_cmd_nx.len = 2'(LEN2); end
                        2'd3: begin w_cmd_nx.addr = bus.ba3_addr; w_cmd_nx.len = 2'(LEN3); end
                    endcase
                    // Writes are always single-word
                    if (bus.ba_wr && (w_pick == 2'd0)) w_cmd_nx.len = 2'd1;
                end
            end
            S_ISSUE: begin
                if (bus.cmd_ack) begin
                    w_state_nx = S_WAIT;
                    w_ack_nx   = w_sel;
                    w_tmo_nx   = '0;
                end
            end
            S_WAIT: begin
                if (bus.cmd_rdy) begin
                    w_state_nx = S_IDLE;
                    w_ptr_nx   = r_cmd.ba;
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_state_nx = S_IDLE;
                    w_ptr_nx   = r_cmd.ba;
                    w_err_nx   = 1'b1;
                end else begin
                    w_tmo_nx = r_tmo + TW'(1);
                end
            end
            S_RFSH: begin
                if (bus.rfsh_ack) begin
                    w_state_nx  = S_IDLE;
                    w_rfsh_done = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'd3;
            r_cmd      <= '0;
            r_tmo      <= '0;
            r_cmd_req  <= 1'b0;
            r_rfsh_req <= 1'b0;
            r_ba_ack   <= 4'b0000;
            r_sch_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_ptr      <= w_ptr_nx;
            r_cmd      <= w_cmd_nx;
            r_tmo      <= w_tmo_nx;
            r_cmd_req  <= (w_state_nx == S_ISSUE);
            r_rfsh_req <= (w_state_nx == S_RFSH);
            r_ba_ack   <= w_ack_nx;
            r_sch_err  <= w_err_nx;
        end
    end

    // Refresh debt: grows every cycle, saturates at three intervals
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_rfsh_done) begin
            r_cnt <= r_cnt - CW'(REFRESH_CYC);
        end else if (r_cnt != CW'(3 * REFRESH_CYC)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign bus.cmd_req  = r_cmd_req;
    assign bus.cmd_wr   = r_cmd.wr;
    assign bus.cmd_ba   = r_cmd.ba;
    assign bus.cmd_addr = r_cmd.addr;
    assign bus.cmd_din  = r_cmd.din;
    assign bus.cmd_mask = r_cmd.mask;
    assign bus.cmd_len  = r_cmd.len;
    assign bus.rfsh_req = r_rfsh_req;
    assign bus.ba_ack   = r_ba_ack;
    assign bus.sch_err  = r_sch_err;
    assign bus.ba_dst   = (r_state == S_WAIT && bus.cmd_dst) ? w_sel : 4'b0000;
    assign bus.ba_dok   = (r_state == S_WAIT && bus.cmd_dok) ? w_sel : 4'b0000;
    assign bus.ba_rdy   = (r_state == S_WAIT && bus.cmd_rdy) ? w_sel : 4'b0000;
endmodule
